// File: rtl/spike_pkg.sv
// -----------------------------------------------------------------------------
// spike_pkg
// Shared definitions for the spiking-neuron fabric (neuron, router, dispatch).
//   ADDR_W       : default width of a spike source address
//   spike_addr_t : spike source address type
//   NULL_ADDR    : reserved address meaning "no spike"
// -----------------------------------------------------------------------------
package spike_pkg;

    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] spike_addr_t;

    localparam spike_addr_t NULL_ADDR = '0;

endpackage : spike_pkg

// File: rtl/spike_fifo.sv
// -----------------------------------------------------------------------------
// spike_fifo
// Synchronous FIFO holding granted spike addresses for the neuron.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i this edge (ignored when full without pop)
//   push_data_i  : address to enqueue
//   pop_i        : remove the head entry this edge (ignored when empty)
//   pop_data_o   : head entry (valid when empty_o is low)
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   count_o      : registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module spike_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = spike_pkg::ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is only allowed when the head leaves on the same
    // edge; the write then reuses the slot being read, which is safe because
    // the read value is sampled before the write takes effect.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // NOTE: storage carries no reset; stale contents are unreachable because
    // the pointers and count are reset, and a resettable array costs far more.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule : spike_fifo

// File: rtl/spike_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// spike_dispatch_arbiter
// Round-robin arbiter collecting spikes from NoC input ports into a FIFO and
// presenting them to the neuron as one-cycle address pulses.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req             : per-requester spike request, held until granted
//   req_addr        : per-requester address, requester i at [i*ADDR_W +: ADDR_W]
//   gnt             : one-hot combinational grant, accepted at the clock edge
//   hold            : neuron busy, suppresses FIFO pops
//   source_address  : registered spike address pulse, 0 = no spike
//   count           : registered FIFO occupancy
//   drop_cnt        : saturating count of null-address requests
// -----------------------------------------------------------------------------
module spike_dispatch_arbiter
    import spike_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = spike_pkg::ADDR_W,
    parameter int DEPTH   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      hold,
    output logic [ADDR_W-1:0]         source_address,
    output logic [$clog2(DEPTH):0]    count,
    output logic [7:0]                drop_cnt
);

    localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [RR_W-1:0]    rr_ptr_q;
    logic [ADDR_W-1:0]  source_address_q;
    logic [7:0]         drop_cnt_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ADDR_W-1:0]  fifo_head;
    logic               pop;
    logic               can_accept;
    logic               found;
    logic [RR_W-1:0]    cand;
    logic [RR_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]  gnt_addr;
    logic               accept;
    logic               is_null;

    assign pop        = !fifo_empty && !hold;
    assign can_accept = !fifo_full || pop;

    // Round-robin search starting just after the last granted requester.
    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        if (rst_n && can_accept) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = RR_W'((int'(rr_ptr_q) + i) % NUM_REQ);
                if (!found && req[cand]) begin
                    found   = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    assign gnt    = found ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign accept = found;

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Null-address requests are consumed by the grant but never queued.
    assign is_null = (gnt_addr == ADDR_W'(NULL_ADDR));

    spike_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (accept && !is_null),
        .push_data_i (gnt_addr),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q         <= '0;
            source_address_q <= '0;
            drop_cnt_q       <= '0;
        end else begin
            if (accept) begin
                rr_ptr_q <= RR_W'((int'(gnt_idx) + 1) % NUM_REQ);
            end
            // Address is a single-cycle pulse: cleared whenever nothing pops.
            source_address_q <= pop ? fifo_head : '0;
            if (accept && is_null && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign source_address = source_address_q;
    assign drop_cnt       = drop_cnt_q;

endmodule : spike_dispatch_arbiter
